// File: rtl/ps_loop_sqncr_if.sv
// ---------------------------------------------------------------------------
// ps_loop_sqncr_if
//   Bundle between the program sequencer and the zero-overhead loop
//   controller.
//   master : the sequencer. Drives loop push/pop, the current fetch address
//            and fetch qualifiers. Receives loop-back redirect and status.
//   slave  : the loop controller (ps_loop_sqncr).
//   Sequencer -> controller: ls_push, ls_strt_add, ls_end_add, ls_cnt,
//                            ls_pop, ps_faddr, ps_fetch_vld, ps_flush
//   Controller -> sequencer: ls_jmp, ls_jmp_add, ls_curcnt, ls_lastiter,
//                            ls_empty, ls_full, ls_ovf
// ---------------------------------------------------------------------------
interface ps_loop_sqncr_if #(
  parameter int AW = 16,
  parameter int CW = 16
);
  logic          ls_push;
  logic [AW-1:0] ls_strt_add;
  logic [AW-1:0] ls_end_add;
  logic [CW-1:0] ls_cnt;
  logic          ls_pop;
  logic [AW-1:0] ps_faddr;
  logic          ps_fetch_vld;
  logic          ps_flush;
  logic          ls_jmp;
  logic [AW-1:0] ls_jmp_add;
  logic [CW-1:0] ls_curcnt;
  logic          ls_lastiter;
  logic          ls_empty;
  logic          ls_full;
  logic          ls_ovf;

  modport master (
    output ls_push, ls_strt_add, ls_end_add, ls_cnt, ls_pop,
           ps_faddr, ps_fetch_vld, ps_flush,
    input  ls_jmp, ls_jmp_add, ls_curcnt, ls_lastiter,
           ls_empty, ls_full, ls_ovf
  );

  modport slave (
    input  ls_push, ls_strt_add, ls_end_add, ls_cnt, ls_pop,
           ps_faddr, ps_fetch_vld, ps_flush,
    output ls_jmp, ls_jmp_add, ls_curcnt, ls_lastiter,
           ls_empty, ls_full, ls_ovf
  );
endinterface

// File: rtl/ps_loop_sqncr.sv
// ---------------------------------------------------------------------------
// ps_loop_sqncr
//   Zero-overhead hardware loop controller. Keeps a stack of active loops
//   {start, end, remaining count}. When the current fetch address hits the
//   end address of the top loop it either requests a loop-back to the start
//   address (count > 1, same cycle) or retires the loop (final iteration).
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous reset, active low
//     bus  : ps_loop_sqncr_if.slave (push/pop, fetch address and qualifiers
//            in; loop-back request, target and stack status out)
//   Parameters: DEPTH nesting depth (>=2), AW address width, CW count width.
// ---------------------------------------------------------------------------
module ps_loop_sqncr #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int CW    = 16
) (
  input  logic           clk,
  input  logic           rst,
  ps_loop_sqncr_if.slave bus
);

  localparam int PW = $clog2(DEPTH + 1);  // pointer holds 0..DEPTH
  localparam int IW = $clog2(DEPTH);      // entry index 0..DEPTH-1

  localparam logic [PW-1:0] PTR_ZERO  = PW'(0);
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] PTR_DEPTH = PW'(DEPTH);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [AW-1:0] ADD_ZERO  = AW'(0);

  logic [AW-1:0] strt_r [DEPTH];
  logic [AW-1:0] end_r  [DEPTH];
  logic [CW-1:0] cnt_r  [DEPTH];
  logic [PW-1:0] ptr_r;
  logic          ovf_r;

  logic          empty_s;
  logic          full_s;
  logic [IW-1:0] top_idx_s;
  logic [AW-1:0] top_strt_s;
  logic [AW-1:0] top_end_s;
  logic [CW-1:0] top_cnt_s;
  logic          match_s;
  logic          dec_s;
  logic          retire_s;
  logic          pop_s;
  logic [CW-1:0] new_cnt_s;

  logic          wr_en_s;
  logic [IW-1:0] wr_idx_s;
  logic          dec_en_s;
  logic [PW-1:0] ptr_nxt_s;
  logic          ovf_set_s;

  assign empty_s    = (ptr_r == PTR_ZERO);
  assign full_s     = (ptr_r == PTR_DEPTH);
  // Wraps when empty; everything that reads the top entry is gated by empty_s.
  assign top_idx_s  = IW'(ptr_r - PTR_ONE);
  assign top_strt_s = strt_r[top_idx_s];
  assign top_end_s  = end_r[top_idx_s];
  assign top_cnt_s  = cnt_r[top_idx_s];

  assign match_s  = !empty_s && bus.ps_fetch_vld && !bus.ps_flush &&
                    (bus.ps_faddr == top_end_s);
  assign dec_s    = match_s && (top_cnt_s > CNT_ONE);
  // Stored counts are never zero, so "not above one" is the final pass.
  assign retire_s = match_s && (top_cnt_s <= CNT_ONE);
  // Explicit pop and retire on the same edge collapse into one pop.
  assign pop_s    = (bus.ls_pop || retire_s) && !empty_s;
  // A zero count still executes the body once.
  assign new_cnt_s = (bus.ls_cnt == CNT_ZERO) ? CNT_ONE : bus.ls_cnt;

  // Stack update decode: which slot is written, decremented, and the new pointer.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = top_idx_s;
    dec_en_s  = 1'b0;
    ptr_nxt_s = ptr_r;
    ovf_set_s = 1'b0;
    if (bus.ls_push && pop_s) begin
      // Push and pop together replace the top entry in place.
      wr_en_s  = 1'b1;
      wr_idx_s = top_idx_s;
    end else if (pop_s) begin
      ptr_nxt_s = ptr_r - PTR_ONE;
    end else begin
      dec_en_s = dec_s;
      if (bus.ls_push) begin
        if (full_s) begin
          ovf_set_s = 1'b1;
        end else begin
          wr_en_s   = 1'b1;
          wr_idx_s  = IW'(ptr_r);
          ptr_nxt_s = ptr_r + PTR_ONE;
        end
      end else begin
        wr_en_s = 1'b0;
      end
    end
  end

  // Loop stack storage, pointer and sticky overflow flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        strt_r[i] <= ADD_ZERO;
        end_r[i]  <= ADD_ZERO;
        cnt_r[i]  <= CNT_ZERO;
      end
      ptr_r <= PTR_ZERO;
      ovf_r <= 1'b0;
    end else begin
      if (wr_en_s) begin
        strt_r[wr_idx_s] <= bus.ls_strt_add;
        end_r[wr_idx_s]  <= bus.ls_end_add;
        cnt_r[wr_idx_s]  <= new_cnt_s;
      end
      // Decrement targets the old top; a same-edge push lands one slot above.
      if (dec_en_s) begin
        cnt_r[top_idx_s] <= top_cnt_s - CNT_ONE;
      end
      ptr_r <= ptr_nxt_s;
      if (ovf_set_s) begin
        ovf_r <= 1'b1;
      end
    end
  end

  assign bus.ls_jmp      = dec_s;
  assign bus.ls_lastiter = retire_s;
  assign bus.ls_jmp_add  = empty_s ? ADD_ZERO : top_strt_s;
  assign bus.ls_curcnt   = empty_s ? CNT_ZERO : top_cnt_s;
  assign bus.ls_empty    = empty_s;
  assign bus.ls_full     = full_s;
  assign bus.ls_ovf      = ovf_r;

endmodule

// File: tb/tb_ps_loop_sqncr.sv
// ---------------------------------------------------------------------------
// tb_ps_loop_sqncr
//   Self-checking bench for ps_loop_sqncr: a directed vector table, hand
//   sequences for nesting, overflow and mid-loop reset, then random stimulus
//   against a queue-based loop-stack reference model.
// ---------------------------------------------------------------------------
module tb_ps_loop_sqncr;
  localparam int DEPTH = 4;
  localparam int AW    = 16;
  localparam int CW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ps_loop_sqncr_if #(.AW(AW), .CW(CW)) bus ();
  ps_loop_sqncr #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic [15:0] s;
    logic [15:0] e;
    logic [15:0] c;
  } ent_t;

  typedef struct {
    logic push; logic [15:0] s; logic [15:0] e; logic [15:0] c; logic pop;
    logic [15:0] fa; logic v; logic f;
    logic jmp; logic [15:0] add; logic [15:0] cur;
    logic last; logic empty; logic full; logic ovf;
  } vec_t;

  ent_t q[$];
  logic ovf_m;
  logic m_jmp, m_last, m_empty, m_full, m_ovf;
  logic [15:0] m_add, m_cur;
  logic a_jmp, a_last, a_empty, a_full, a_ovf;
  logic [15:0] a_add, a_cur;
  int n_vec = 0;
  int n_mis = 0;
  vec_t tbl [20];

  function automatic vec_t mkv(logic push, logic [15:0] s, logic [15:0] e,
      logic [15:0] c, logic pop, logic [15:0] fa, logic v, logic f,
      logic jmp, logic [15:0] add, logic [15:0] cur, logic last,
      logic empty, logic full, logic ovf);
    vec_t r;
    r.push = push; r.s = s; r.e = e; r.c = c; r.pop = pop;
    r.fa = fa; r.v = v; r.f = f; r.jmp = jmp; r.add = add; r.cur = cur;
    r.last = last; r.empty = empty; r.full = full; r.ovf = ovf;
    return r;
  endfunction

  task automatic cmp(string tag, string fld, int act, int exp);
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s.%s: got 0x%0h expected 0x%0h", tag, fld, act, exp);
    end
  endtask

  task automatic chk(string tag, logic jmp, logic [15:0] add, logic [15:0] cur,
      logic last, logic empty, logic full, logic ovf);
    n_vec++;
    cmp(tag, "jmp", int'(a_jmp), int'(jmp));
    cmp(tag, "jmp_add", int'(a_add), int'(add));
    cmp(tag, "curcnt", int'(a_cur), int'(cur));
    cmp(tag, "lastiter", int'(a_last), int'(last));
    cmp(tag, "empty", int'(a_empty), int'(empty));
    cmp(tag, "full", int'(a_full), int'(full));
    cmp(tag, "ovf", int'(a_ovf), int'(ovf));
  endtask

  task automatic sample();
    a_jmp = bus.ls_jmp;     a_add = bus.ls_jmp_add; a_cur = bus.ls_curcnt;
    a_last = bus.ls_lastiter; a_empty = bus.ls_empty;
    a_full = bus.ls_full;   a_ovf = bus.ls_ovf;
  endtask

  // Reference: what the loop stack presents for the given fetch inputs.
  task automatic model_eval(logic [15:0] fa, logic v, logic f);
    ent_t t;
    logic hit;
    hit = 1'b0;
    m_add = 16'h0; m_cur = 16'h0;
    if (q.size() > 0) begin
      t = q[q.size()-1];
      m_add = t.s; m_cur = t.c;
      hit = v && !f && (fa == t.e);
    end
    m_jmp   = hit && (m_cur > 16'd1);
    m_last  = hit && (m_cur == 16'd1);
    m_empty = (q.size() == 0);
    m_full  = (q.size() == DEPTH);
    m_ovf   = ovf_m;
  endtask

  // Reference: stack evolution across one clock edge.
  task automatic model_step(logic push, logic [15:0] s, logic [15:0] e,
      logic [15:0] c, logic pop);
    ent_t n, t;
    logic do_pop;
    n.s = s; n.e = e; n.c = (c == 16'd0) ? 16'd1 : c;
    do_pop = (pop || m_last) && (q.size() > 0);
    if (push && do_pop) begin
      q[q.size()-1] = n;
    end else begin
      if (do_pop) begin
        void'(q.pop_back());
      end else if (m_jmp) begin
        t = q[q.size()-1];
        t.c = t.c - 16'd1;
        q[q.size()-1] = t;
      end
      if (push) begin
        if (q.size() < DEPTH) q.push_back(n);
        else ovf_m = 1'b1;
      end
    end
  endtask

  task automatic drive(logic push, logic [15:0] s, logic [15:0] e, logic [15:0] c,
      logic pop, logic [15:0] fa, logic v, logic f);
    bus.ls_push = push; bus.ls_strt_add = s; bus.ls_end_add = e; bus.ls_cnt = c;
    bus.ls_pop = pop; bus.ps_faddr = fa; bus.ps_fetch_vld = v; bus.ps_flush = f;
  endtask

  // One sequencer cycle: drive after the falling edge, sample, then clock.
  task automatic cyc(logic push, logic [15:0] s, logic [15:0] e, logic [15:0] c,
      logic pop, logic [15:0] fa, logic v, logic f);
    @(negedge clk);
    drive(push, s, e, c, pop, fa, v, f);
    #1;
    sample();
    model_eval(fa, v, f);
    @(posedge clk);
    model_step(push, s, e, c, pop);
  endtask

  initial begin
    int pc, body, j23, j25;
    logic done;

    // Single loop x3, single-pass zero-count loop, flush/idle suppression.
    tbl[0]  = mkv(1, 16'h10, 16'h12, 16'd3, 0, 16'h00, 0, 0, 0, 16'h00, 16'd0, 0, 1, 0, 0);
    tbl[1]  = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h10, 1, 0, 0, 16'h10, 16'd3, 0, 0, 0, 0);
    tbl[2]  = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h11, 1, 0, 0, 16'h10, 16'd3, 0, 0, 0, 0);
    tbl[3]  = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h12, 1, 0, 1, 16'h10, 16'd3, 0, 0, 0, 0);
    tbl[4]  = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h10, 1, 0, 0, 16'h10, 16'd2, 0, 0, 0, 0);
    tbl[5]  = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h11, 1, 0, 0, 16'h10, 16'd2, 0, 0, 0, 0);
    tbl[6]  = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h12, 1, 0, 1, 16'h10, 16'd2, 0, 0, 0, 0);
    tbl[7]  = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h10, 1, 0, 0, 16'h10, 16'd1, 0, 0, 0, 0);
    tbl[8]  = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h11, 1, 0, 0, 16'h10, 16'd1, 0, 0, 0, 0);
    tbl[9]  = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h12, 1, 0, 0, 16'h10, 16'd1, 1, 0, 0, 0);
    tbl[10] = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h13, 1, 0, 0, 16'h00, 16'd0, 0, 1, 0, 0);
    tbl[11] = mkv(1, 16'h30, 16'h30, 16'd0, 0, 16'h13, 0, 0, 0, 16'h00, 16'd0, 0, 1, 0, 0);
    tbl[12] = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h30, 1, 0, 0, 16'h30, 16'd1, 1, 0, 0, 0);
    tbl[13] = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h31, 1, 0, 0, 16'h00, 16'd0, 0, 1, 0, 0);
    tbl[14] = mkv(1, 16'h40, 16'h42, 16'd3, 0, 16'h31, 0, 0, 0, 16'h00, 16'd0, 0, 1, 0, 0);
    tbl[15] = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h42, 1, 1, 0, 16'h40, 16'd3, 0, 0, 0, 0);
    tbl[16] = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h42, 0, 0, 0, 16'h40, 16'd3, 0, 0, 0, 0);
    tbl[17] = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h42, 1, 0, 1, 16'h40, 16'd3, 0, 0, 0, 0);
    tbl[18] = mkv(0, 16'h00, 16'h00, 16'd0, 1, 16'h40, 1, 0, 0, 16'h40, 16'd2, 0, 0, 0, 0);
    tbl[19] = mkv(0, 16'h00, 16'h00, 16'd0, 0, 16'h41, 1, 0, 0, 16'h00, 16'd0, 0, 1, 0, 0);

    // Reset state.
    drive(0, 16'h0, 16'h0, 16'd0, 0, 16'h0, 0, 0);
    q.delete(); ovf_m = 1'b0;
    #12;
    sample();
    chk("reset", 0, 16'h0, 16'd0, 0, 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      cyc(tbl[i].push, tbl[i].s, tbl[i].e, tbl[i].c, tbl[i].pop, tbl[i].fa, tbl[i].v, tbl[i].f);
      chk($sformatf("tbl%0d", i), tbl[i].jmp, tbl[i].add, tbl[i].cur,
          tbl[i].last, tbl[i].empty, tbl[i].full, tbl[i].ovf);
    end

    // Nested loops: outer(0x20..0x25,2) with inner(0x21..0x23,2) pushed at 0x20.
    cyc(1, 16'h20, 16'h25, 16'd2, 0, 16'h0, 0, 0);
    pc = 32'h20; body = 0; j23 = 0; j25 = 0; done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      cyc(pc == 32'h20, 16'h21, 16'h23, 16'd2, 0, 16'(pc), 1, 0);
      chk("nest", m_jmp, m_add, m_cur, m_last, m_empty, m_full, m_ovf);
      if (pc >= 32'h20 && pc <= 32'h25) body++;
      if (a_jmp && pc == 32'h23) j23++;
      if (a_jmp && pc == 32'h25) j25++;
      pc = a_jmp ? int'(a_add) : pc + 1;
      if (pc == 32'h26) done = 1'b1;
    end
    n_vec++;
    cmp("nest", "exit_reached", int'(done), 1);
    cmp("nest", "body_fetches", body, 18);
    cmp("nest", "jmp_at_23", j23, 2);
    cmp("nest", "jmp_at_25", j25, 1);
    cyc(0, 16'h0, 16'h0, 16'd0, 0, 16'h26, 1, 0);
    chk("nest_end", 0, 16'h0, 16'd0, 0, 1, 0, 0);

    // Overflow: five pushes into a four-deep stack, then one pop.
    for (int i = 0; i < 5; i++) begin
      cyc(1, 16'h100 + 16'(i), 16'h200 + 16'(i), 16'(i + 1), 0, 16'h0, 0, 0);
      chk("ovf_push", m_jmp, m_add, m_cur, m_last, m_empty, m_full, m_ovf);
      if (i == 4) chk("ovf_full", 0, 16'h103, 16'd4, 0, 0, 1, 0);
    end
    cyc(0, 16'h0, 16'h0, 16'd0, 0, 16'h0, 0, 0);
    chk("ovf_set", 0, 16'h103, 16'd4, 0, 0, 1, 1);
    cyc(0, 16'h0, 16'h0, 16'd0, 1, 16'h0, 0, 0);
    cyc(0, 16'h0, 16'h0, 16'd0, 0, 16'h0, 0, 0);
    chk("ovf_pop", 0, 16'h102, 16'd3, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) cyc(0, 16'h0, 16'h0, 16'd0, 1, 16'h0, 0, 0);

    // Asynchronous reset in the middle of an iteration.
    cyc(1, 16'h50, 16'h52, 16'd3, 0, 16'h0, 0, 0);
    cyc(0, 16'h0, 16'h0, 16'd0, 0, 16'h50, 1, 0);
    cyc(0, 16'h0, 16'h0, 16'd0, 0, 16'h51, 1, 0);
    cyc(0, 16'h0, 16'h0, 16'd0, 0, 16'h52, 1, 0);
    chk("pre_rst_jmp", 1, 16'h50, 16'd3, 0, 0, 0, 1);
    cyc(0, 16'h0, 16'h0, 16'd0, 0, 16'h50, 1, 0);
    @(negedge clk);
    drive(0, 16'h0, 16'h0, 16'd0, 0, 16'h51, 1, 0);
    #1;
    sample();
    chk("mid_loop", 0, 16'h50, 16'd2, 0, 0, 0, 1);
    drive(0, 16'h0, 16'h0, 16'd0, 0, 16'h52, 1, 0);
    #1;
    rst = 1'b0;
    #1;
    sample();
    chk("async_rst", 0, 16'h0, 16'd0, 0, 1, 0, 0);
    q.delete(); ovf_m = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    cyc(0, 16'h0, 16'h0, 16'd0, 0, 16'h52, 1, 0);
    chk("post_rst", 0, 16'h0, 16'd0, 0, 1, 0, 0);

    // Random traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 3) == 0, 16'($urandom_range(0, 15)), 16'($urandom_range(0, 7)),
          16'($urandom_range(0, 3)), $urandom_range(0, 7) == 0, 16'($urandom_range(0, 7)),
          $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0);
      chk("rnd", m_jmp, m_add, m_cur, m_last, m_empty, m_full, m_ovf);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
